// File: rtl/fifo_wr_arbiter_if.sv
// Handshake bundle between NumReq burst requesters and a single FIFO write port.
// The arbiter attaches through the slave modport; the requester/FIFO side uses master.
interface fifo_wr_arbiter_if #(
    parameter int NumReq = 2,
    parameter int Width  = 32
);
    localparam int IdWidth = ($clog2(NumReq) > 1) ? $clog2(NumReq) : 1;

    logic [NumReq-1:0]        req_valid_i;
    logic [NumReq*Width-1:0]  req_data_i;
    logic [NumReq-1:0]        req_last_i;
    logic [NumReq-1:0]        req_ready_o;
    logic                     fifo_wr_valid_o;
    logic [IdWidth+Width-1:0] fifo_wr_data_o;
    logic                     fifo_wr_ready_i;
    logic [NumReq-1:0]        grant_o;
    logic                     busy_o;

    modport slave (
        input  req_valid_i,
        input  req_data_i,
        input  req_last_i,
        input  fifo_wr_ready_i,
        output req_ready_o,
        output fifo_wr_valid_o,
        output fifo_wr_data_o,
        output grant_o,
        output busy_o
    );

    modport master (
        output req_valid_i,
        output req_data_i,
        output req_last_i,
        output fifo_wr_ready_i,
        input  req_ready_o,
        input  fifo_wr_valid_o,
        input  fifo_wr_data_o,
        input  grant_o,
        input  busy_o
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter with burst locking: zero-latency grant, the winner
// keeps the FIFO port until the beat flagged last is accepted.
module fifo_wr_arbiter #(
    parameter int NumReq = 2,
    parameter int Width  = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    fifo_wr_arbiter_if.slave bus
);
    localparam int IdWidth = ($clog2(NumReq) > 1) ? $clog2(NumReq) : 1;

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    localparam logic [IdWidth-1:0] LastIdx = IdWidth'(NumReq - 1);

    logic [0:0]         state_q, state_d;
    logic [IdWidth-1:0] rr_ptr_q, rr_ptr_d;
    logic [IdWidth-1:0] owner_q, owner_d;

    logic [IdWidth-1:0] winner;
    logic               has_winner;
    logic [NumReq-1:0]  grant;
    logic               wr_valid;
    logic               win_last;
    logic               accept;

    // Explicit wrap keeps the pointer inside 0..NumReq-1 for non-power-of-two counts.
    function automatic logic [IdWidth-1:0] wrap_inc(input logic [IdWidth-1:0] idx);
        return (idx == LastIdx) ? '0 : idx + 1'b1;
    endfunction

    function automatic logic [IdWidth-1:0] rot_idx(input logic [IdWidth-1:0] ptr, input int k);
        int s;
        s = int'(ptr) + k;
        if (s >= NumReq) begin
            s = s - NumReq;
        end
        return IdWidth'(s);
    endfunction

    always_comb begin
        winner     = owner_q;
        has_winner = 1'b0;
        if (state_q == LOCKED) begin
            winner     = owner_q;
            has_winner = 1'b1;
        end else begin
            // Walking from the far end down leaves the candidate closest to rr_ptr.
            for (int k = NumReq - 1; k >= 0; k--) begin
                if (bus.req_valid_i[rot_idx(rr_ptr_q, k)]) begin
                    winner     = rot_idx(rr_ptr_q, k);
                    has_winner = 1'b1;
                end
            end
        end
    end

    always_comb begin
        grant = '0;
        if (has_winner) begin
            grant[winner] = 1'b1;
        end
    end

    assign wr_valid = has_winner & bus.req_valid_i[winner];
    assign win_last = bus.req_last_i[winner];
    assign accept   = wr_valid & bus.fifo_wr_ready_i;

    assign bus.grant_o         = grant;
    assign bus.fifo_wr_valid_o = wr_valid;
    assign bus.fifo_wr_data_o  = {winner, bus.req_data_i[winner*Width +: Width]};
    assign bus.req_ready_o     = grant & {NumReq{bus.fifo_wr_ready_i}};
    assign bus.busy_o          = (state_q == LOCKED);

    // In LOCKED the winner is the owner, so one update rule covers both states.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        if (accept) begin
            if (win_last) begin
                state_d  = IDLE;
                rr_ptr_d = wrap_inc(winner);
            end else begin
                state_d = LOCKED;
                owner_d = winner;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
        end
    end
endmodule
